// File: rtl/cyclic_lamp_timed.sv
// Timed RED -> GREEN -> YELLOW lamp cycler with advance enable and a latched pedestrian request.
// Define FLASH_MODE_EN to add the flash input and the flashing YELLOW/OFF override.
module cyclic_lamp_timed #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int RED_CYC    = 6,
  parameter int MIN_GREEN  = 4,
`ifdef FLASH_MODE_EN
  parameter int FLASH_CYC  = 4,
`endif
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
`ifdef FLASH_MODE_EN
  input  logic       flash,
`endif
  output logic [2:0] light,
  output logic       walk,
  output logic       ped_ack
);

  typedef enum logic [2:0] {
    ST_RED       = 3'd0,
    ST_GREEN     = 3'd1,
    ST_YELLOW    = 3'd2,
    ST_FLASH_ON  = 3'd3,
    ST_FLASH_OFF = 3'd4
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b000;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
`ifdef FLASH_MODE_EN
  localparam logic [2:0] LIGHT_OFF    = 3'b011;
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYC - 1);
`endif

  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RED_LAST       = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_GREEN_LAST = CNT_W'(MIN_GREEN - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             pend_r;
  logic             pend_nxt_s;
  logic             req_s;
  logic             serve_s;
  logic             phase_done_s;
  logic [2:0]       light_r;
  logic [2:0]       light_nxt_s;
  logic             walk_r;
  logic             walk_nxt_s;
  logic             ack_r;
  logic             ack_nxt_s;

  // Last counter value of the dwell belonging to a state.
  function automatic logic [CNT_W-1:0] last_cnt(input state_t st);
    logic [CNT_W-1:0] v;
    case (st)
      ST_RED:       v = RED_LAST;
      ST_GREEN:     v = GREEN_LAST;
      ST_YELLOW:    v = YELLOW_LAST;
`ifdef FLASH_MODE_EN
      ST_FLASH_ON:  v = FLASH_LAST;
      ST_FLASH_OFF: v = FLASH_LAST;
`endif
      default:      v = {CNT_W{1'b0}};
    endcase
    return v;
  endfunction

  // Lamp code shown while in a state.
  function automatic logic [2:0] light_code(input state_t st);
    logic [2:0] v;
    case (st)
      ST_RED:       v = LIGHT_RED;
      ST_GREEN:     v = LIGHT_GREEN;
      ST_YELLOW:    v = LIGHT_YELLOW;
`ifdef FLASH_MODE_EN
      ST_FLASH_ON:  v = LIGHT_YELLOW;
      ST_FLASH_OFF: v = LIGHT_OFF;
`endif
      default:      v = LIGHT_RED;
    endcase
    return v;
  endfunction

  assign req_s = pend_r | ped_req;

  // A GREEN dwell may be cut short once MIN_GREEN cycles have elapsed with a request waiting.
  assign phase_done_s = (cnt_r == last_cnt(state_r)) ||
                        ((state_r == ST_GREEN) && req_s && (cnt_r >= MIN_GREEN_LAST));

  // State, counter, request latch and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RED;
      cnt_r   <= {CNT_W{1'b0}};
      pend_r  <= 1'b0;
      light_r <= LIGHT_RED;
      walk_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      pend_r  <= pend_nxt_s;
      light_r <= light_nxt_s;
      walk_r  <= walk_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  // Next state and counter; the request is served on the YELLOW -> RED edge only.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    serve_s     = 1'b0;
    if (en) begin
      if (phase_done_s) begin
        cnt_nxt_s = {CNT_W{1'b0}};
        case (state_r)
          ST_RED:    state_nxt_s = ST_GREEN;
          ST_GREEN:  state_nxt_s = ST_YELLOW;
          ST_YELLOW: begin
            state_nxt_s = ST_RED;
            serve_s     = req_s;
          end
          default:   state_nxt_s = ST_RED;
        endcase
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
`ifdef FLASH_MODE_EN
    // Flash overrides normal cycling and ignores en; leaving flash never serves a request.
    if (flash) begin
      serve_s = 1'b0;
      if ((state_r == ST_FLASH_ON) || (state_r == ST_FLASH_OFF)) begin
        if (cnt_r == FLASH_LAST) begin
          state_nxt_s = (state_r == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = state_r;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end else begin
        state_nxt_s = ST_FLASH_ON;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    end else if ((state_r == ST_FLASH_ON) || (state_r == ST_FLASH_OFF)) begin
      serve_s     = 1'b0;
      state_nxt_s = ST_RED;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      serve_s = serve_s;
    end
`endif
  end

  // Next lamp outputs and request latch, derived from the chosen transition.
  always_comb begin
    light_nxt_s = light_code(state_nxt_s);
    ack_nxt_s   = serve_s;
    pend_nxt_s  = req_s & ~serve_s;
    if (state_nxt_s != ST_RED) begin
      walk_nxt_s = 1'b0;
    end else if (state_r == ST_RED) begin
      walk_nxt_s = walk_r;
    end else begin
      walk_nxt_s = serve_s;
    end
  end

  assign light   = light_r;
  assign walk    = walk_r;
  assign ped_ack = ack_r;

endmodule

// File: tb/tb_cyclic_lamp_timed.sv
// Self-checking bench for cyclic_lamp_timed: directed vector table plus randomized run against a reference model.
module tb_cyclic_lamp_timed;

  localparam int G_CYC = 8;
  localparam int Y_CYC = 3;
  localparam int R_CYC = 6;
  localparam int MIN_G = 4;

  localparam logic [2:0] RED = 3'b000;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ped_req = 1'b0;
`ifdef FLASH_MODE_EN
  logic       flash = 1'b0;
`endif
  logic [2:0] light;
  logic       walk;
  logic       ped_ack;

  typedef struct {
    logic       rst;
    logic       en;
    logic       req;
    logic [2:0] light;
    logic       walk;
    logic       ack;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: phase index 0=RED 1=GREEN 2=YELLOW, time spent in the phase.
  int         dur[3]   = '{R_CYC, G_CYC, Y_CYC};
  logic [2:0] codes[3] = '{3'b000, 3'b001, 3'b010};
  int         m_phase, m_elapsed;
  bit         m_pend, m_walk, m_ack;

  cyclic_lamp_timed #(
    .GREEN_CYC (G_CYC),
    .YELLOW_CYC(Y_CYC),
    .RED_CYC   (R_CYC),
    .MIN_GREEN (MIN_G),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ped_req(ped_req),
`ifdef FLASH_MODE_EN
    .flash  (flash),
`endif
    .light  (light),
    .walk   (walk),
    .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic q,
                     input logic [2:0] l, input logic w, input logic a);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.light = l; v.walk = w; v.ack = a;
    tbl.push_back(v);
  endtask

  task automatic add_run(input int n, input logic [2:0] l, input logic w);
    for (int i = 0; i < n; i++) add(1'b0, 1'b1, 1'b0, l, w, 1'b0);
  endtask

  task automatic apply(input logic r, input logic e, input logic q);
    rst = r; en = e; ped_req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] l, input logic w, input logic a);
    n_vec++;
    if (light !== l || walk !== w || ped_ack !== a) begin
      n_miss++;
      $display("FAIL %s: got light=%b walk=%b ped_ack=%b, expected light=%b walk=%b ped_ack=%b",
               name, light, walk, ped_ack, l, w, a);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic q);
    bit req, serve, adv;
    serve = 1'b0;
    m_ack = 1'b0;
    if (r) begin
      m_phase = 0; m_elapsed = 0; m_pend = 1'b0; m_walk = 1'b0;
    end else begin
      req = m_pend || q;
      if (e) begin
        adv = (m_elapsed + 1 == dur[m_phase]) ||
              (m_phase == 1 && req && m_elapsed + 1 >= MIN_G);
        if (adv) begin
          if (m_phase == 2) begin
            serve = req; m_walk = req; m_ack = req;
          end else if (m_phase == 0) begin
            m_walk = 1'b0;
          end
          m_phase   = (m_phase + 1) % 3;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      m_pend = req && !serve;
    end
  endtask

  initial begin
    // Natural cycle after a two-cycle reset.
    add(1'b1, 1'b1, 1'b0, RED, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, RED, 1'b0, 1'b0);
    add_run(5, RED, 1'b0);
    add_run(8, GRN, 1'b0); add_run(3, YEL, 1'b0); add_run(6, RED, 1'b0);
    add_run(8, GRN, 1'b0); add_run(3, YEL, 1'b0); add_run(6, RED, 1'b0);
    // en=0 for five cycles at GREEN cnt=3 stretches GREEN to 13 visible cycles.
    add_run(4, GRN, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, GRN, 1'b0, 1'b0);
    add_run(4, GRN, 1'b0); add_run(3, YEL, 1'b0); add_run(6, RED, 1'b0);
    // Request at GREEN cnt=1: GREEN cut to 4, served RED with walk.
    add_run(2, GRN, 1'b0);
    add(1'b0, 1'b1, 1'b1, GRN, 1'b0, 1'b0);
    add_run(1, GRN, 1'b0); add_run(3, YEL, 1'b0);
    add(1'b0, 1'b1, 1'b0, RED, 1'b1, 1'b1);
    add_run(5, RED, 1'b1);
    // Request at GREEN cnt=5, then another during the walk RED.
    add_run(6, GRN, 1'b0);
    add(1'b0, 1'b1, 1'b1, YEL, 1'b0, 1'b0);
    add_run(2, YEL, 1'b0);
    add(1'b0, 1'b1, 1'b0, RED, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b1, RED, 1'b1, 1'b0);
    add_run(4, RED, 1'b1);
    add_run(4, GRN, 1'b0); add_run(3, YEL, 1'b0);
    add(1'b0, 1'b1, 1'b0, RED, 1'b1, 1'b1);
    add_run(5, RED, 1'b1);
    // Reset at YELLOW cnt=1 with a request pending discards it.
    add_run(2, GRN, 1'b0);
    add(1'b0, 1'b1, 1'b1, GRN, 1'b0, 1'b0);
    add_run(1, GRN, 1'b0); add_run(2, YEL, 1'b0);
    add(1'b1, 1'b1, 1'b0, RED, 1'b0, 1'b0);
    add_run(5, RED, 1'b0);
    add_run(8, GRN, 1'b0); add_run(3, YEL, 1'b0); add_run(6, RED, 1'b0);
    // Reset wins over en=0 mid-GREEN.
    add_run(3, GRN, 1'b0);
    add(1'b1, 1'b0, 1'b0, RED, 1'b0, 1'b0);
    add_run(5, RED, 1'b0);
    // en=0 just before and just after the serve edge.
    add_run(2, GRN, 1'b0);
    add(1'b0, 1'b1, 1'b1, GRN, 1'b0, 1'b0);
    add_run(1, GRN, 1'b0); add_run(3, YEL, 1'b0);
    add(1'b0, 1'b0, 1'b0, YEL, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, RED, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, RED, 1'b1, 1'b0);
    add_run(5, RED, 1'b1);
    add_run(1, GRN, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].light, tbl[i].walk, tbl[i].ack);
    end

    // Randomized run against the reference model, starting from reset.
    model_step(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    check("rand_reset", codes[m_phase], m_walk, m_ack);
    for (int i = 0; i < 3000; i++) begin
      logic r, e, q;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 7) != 0);
      q = ($urandom_range(0, 11) == 0);
      model_step(r, e, q);
      apply(r, e, q);
      check($sformatf("rand%0d", i), codes[m_phase], m_walk, m_ack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
